// File: rtl/fft_ctrl.sv
// fft_ctrl: sequencer for an in-place radix-2 DIT FFT datapath.
//
// Loads N samples over a valid/ready handshake while generating buffer write
// addresses. It then issues every butterfly (operand addresses, twiddle index,
// stage), one per cycle. After a PIPE_LAT-cycle drain it streams the N result
// bin read addresses out over a valid/ready handshake.
//
// Build option: FFT_CTRL_BITREV_EN
//   defined   - bit-reversed load addresses, natural-order rd_addr
//   undefined - natural-order load addresses, bit-reversed rd_addr
//   The butterfly schedule is the same in both builds.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   in_valid/in_ready sample handshake (LOAD only)
//   load_we/load_addr buffer write strobe and address
//   bf_valid          butterfly issue strobe (COMPUTE)
//   bf_a_addr         upper operand address
//   bf_b_addr         lower operand address (a + half)
//   bf_tw_idx         twiddle ROM index
//   bf_stage          current stage number
//   out_valid         result bin address valid (UNLOAD)
//   out_ready         downstream consumes the bin
//   rd_addr           buffer read address of the current bin
//   out_last          high with out_valid on bin N-1
//   frame_done        one-cycle pulse after the final bin handshake
//   busy              high in COMPUTE, DRAIN or UNLOAD
module fft_ctrl #(
   parameter int unsigned N        = 8,
   parameter int unsigned LOG2N    = 3,
   parameter int unsigned PIPE_LAT = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             load_we,
   output logic [LOG2N-1:0] load_addr,
   output logic             bf_valid,
   output logic [LOG2N-1:0] bf_a_addr,
   output logic [LOG2N-1:0] bf_b_addr,
   output logic [LOG2N-2:0] bf_tw_idx,
   output logic [LOG2N-1:0] bf_stage,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LOG2N-1:0] rd_addr,
   output logic             out_last,
   output logic             frame_done,
   output logic             busy
);

   typedef enum logic [1:0] {StLoad, StCompute, StDrain, StUnload} state_e;

   state_e           r_state, r_state_d;
   logic [LOG2N-1:0] r_sample_cnt, r_sample_cnt_d;
   logic [LOG2N-2:0] r_bf_cnt, r_bf_cnt_d;
   logic [LOG2N-1:0] r_stage, r_stage_d;
   logic [2:0]       r_drain_cnt, r_drain_cnt_d;
   logic [LOG2N-1:0] r_bin_cnt, r_bin_cnt_d;
   logic             r_frame_done, r_frame_done_d;

   logic [LOG2N-1:0] w_b_ext, w_half, w_pos, w_grp, w_a, w_tw_full;
   logic             w_accept, w_out_hs;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < int'(LOG2N); i++) begin
         r[i] = v[LOG2N-1-i];
      end
      return r;
   endfunction

   // Butterfly address decode from (stage, butterfly index).
   always_comb begin
      w_b_ext   = {1'b0, r_bf_cnt};
      w_half    = LOG2N'(1) << r_stage;
      w_pos     = w_b_ext & (w_half - LOG2N'(1));
      w_grp     = w_b_ext >> r_stage;
      w_a       = (w_grp << (r_stage + LOG2N'(1))) | w_pos;
      w_tw_full = w_pos << (LOG2N'(LOG2N - 1) - r_stage);
   end

   always_comb begin
      in_ready  = (r_state == StLoad) && !reset;
      w_accept  = in_valid && in_ready;
      load_we   = w_accept;
`ifdef FFT_CTRL_BITREV_EN
      load_addr = bitrev(r_sample_cnt);
      rd_addr   = r_bin_cnt;
`else
      load_addr = r_sample_cnt;
      rd_addr   = bitrev(r_bin_cnt);
`endif
      bf_valid  = (r_state == StCompute);
      bf_a_addr = '0;
      bf_b_addr = '0;
      bf_tw_idx = '0;
      if (bf_valid) begin
         bf_a_addr = w_a;
         bf_b_addr = w_a + w_half;
         bf_tw_idx = w_tw_full[LOG2N-2:0];
      end
      bf_stage   = r_stage;
      out_valid  = (r_state == StUnload);
      w_out_hs   = out_valid && out_ready;
      out_last   = out_valid && (r_bin_cnt == LOG2N'(N - 1));
      frame_done = r_frame_done;
      busy       = (r_state != StLoad);
   end

   always_comb begin
      r_state_d      = r_state;
      r_sample_cnt_d = r_sample_cnt;
      r_bf_cnt_d     = r_bf_cnt;
      r_stage_d      = r_stage;
      r_drain_cnt_d  = r_drain_cnt;
      r_bin_cnt_d    = r_bin_cnt;
      r_frame_done_d = 1'b0;
      unique case (r_state)
         StLoad: begin
            if (w_accept) begin
               if (r_sample_cnt == LOG2N'(N - 1)) begin
                  r_sample_cnt_d = '0;
                  r_state_d      = StCompute;
               end else begin
                  r_sample_cnt_d = r_sample_cnt + LOG2N'(1);
               end
            end
         end
         StCompute: begin
            if (r_bf_cnt == (LOG2N-1)'(N/2 - 1)) begin
               r_bf_cnt_d = '0;
               if (r_stage == LOG2N'(LOG2N - 1)) begin
                  r_stage_d = '0;
                  r_state_d = (PIPE_LAT > 0) ? StDrain : StUnload;
               end else begin
                  r_stage_d = r_stage + LOG2N'(1);
               end
            end else begin
               r_bf_cnt_d = r_bf_cnt + (LOG2N-1)'(1);
            end
         end
         StDrain: begin
            if (r_drain_cnt == 3'(PIPE_LAT - 1)) begin
               r_drain_cnt_d = '0;
               r_state_d     = StUnload;
            end else begin
               r_drain_cnt_d = r_drain_cnt + 3'd1;
            end
         end
         StUnload: begin
            if (w_out_hs) begin
               if (r_bin_cnt == LOG2N'(N - 1)) begin
                  r_bin_cnt_d    = '0;
                  r_frame_done_d = 1'b1;
                  r_state_d      = StLoad;
               end else begin
                  r_bin_cnt_d = r_bin_cnt + LOG2N'(1);
               end
            end
         end
         default: r_state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= StLoad;
         r_sample_cnt <= '0;
         r_bf_cnt     <= '0;
         r_stage      <= '0;
         r_drain_cnt  <= '0;
         r_bin_cnt    <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= r_state_d;
         r_sample_cnt <= r_sample_cnt_d;
         r_bf_cnt     <= r_bf_cnt_d;
         r_stage      <= r_stage_d;
         r_drain_cnt  <= r_drain_cnt_d;
         r_bin_cnt    <= r_bin_cnt_d;
         r_frame_done <= r_frame_done_d;
      end
   end

endmodule

// File: tb/tb_fft_ctrl.sv
// Directed bench for fft_ctrl with default parameters (N=8, PIPE_LAT=2).
module tb_fft_ctrl;

   localparam int unsigned N        = 8;
   localparam int unsigned LOG2N    = 3;
   localparam int unsigned PIPE_LAT = 2;

   logic             clk;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic             load_we;
   logic [LOG2N-1:0] load_addr;
   logic             bf_valid;
   logic [LOG2N-1:0] bf_a_addr;
   logic [LOG2N-1:0] bf_b_addr;
   logic [LOG2N-2:0] bf_tw_idx;
   logic [LOG2N-1:0] bf_stage;
   logic             out_valid;
   logic             out_ready;
   logic [LOG2N-1:0] rd_addr;
   logic             out_last;
   logic             frame_done;
   logic             busy;

   int n_checks = 0;
   int n_errors = 0;

   int exp_load [8];
   int exp_rd   [8];
   int exp_a    [12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
   int exp_b    [12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
   int exp_tw   [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
   int exp_stg  [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2};

   fft_ctrl #(
      .N        (N),
      .LOG2N    (LOG2N),
      .PIPE_LAT (PIPE_LAT)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .load_we    (load_we),
      .load_addr  (load_addr),
      .bf_valid   (bf_valid),
      .bf_a_addr  (bf_a_addr),
      .bf_b_addr  (bf_b_addr),
      .bf_tw_idx  (bf_tw_idx),
      .bf_stage   (bf_stage),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .rd_addr    (rd_addr),
      .out_last   (out_last),
      .frame_done (frame_done),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one cycle; sampling happens 1 time unit after the falling edge.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   initial begin
      int d;
      int e;
      int stall;
      int guard;

`ifdef FFT_CTRL_BITREV_EN
      exp_load = '{0, 4, 2, 6, 1, 5, 3, 7};
      exp_rd   = '{0, 1, 2, 3, 4, 5, 6, 7};
`else
      exp_load = '{0, 1, 2, 3, 4, 5, 6, 7};
      exp_rd   = '{0, 4, 2, 6, 1, 5, 3, 7};
`endif

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check_eq("rst_in_ready", int'(in_ready), 0);
      check_eq("rst_load_we", int'(load_we), 0);
      check_eq("rst_bf_valid", int'(bf_valid), 0);
      check_eq("rst_out_valid", int'(out_valid), 0);
      check_eq("rst_out_last", int'(out_last), 0);
      check_eq("rst_frame_done", int'(frame_done), 0);
      check_eq("rst_busy", int'(busy), 0);
      check_eq("rst_bf_b_addr", int'(bf_b_addr), 0);
      check_eq("rst_rd_addr", int'(rd_addr), 0);
      in_valid = 1'b1;
      #1;
      check_eq("rst_in_ready_valid", int'(in_ready), 0);
      check_eq("rst_load_we_valid", int'(load_we), 0);
      reset = 1'b0;
      #1;

      // Frame 1: load with in_valid held high
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("load_ready_%0d", i), int'(in_ready), 1);
         check_eq($sformatf("load_we_%0d", i), int'(load_we), 1);
         check_eq($sformatf("load_addr_%0d", i), int'(load_addr), exp_load[i]);
         tick();
      end
      check_eq("after_load_in_ready", int'(in_ready), 0);
      check_eq("after_load_we", int'(load_we), 0);
      check_eq("after_load_busy", int'(busy), 1);

      // Compute schedule, first issue is the cycle after the last accept
      for (int k = 0; k < 12; k++) begin
         check_eq($sformatf("bf_valid_%0d", k), int'(bf_valid), 1);
         check_eq($sformatf("bf_a_%0d", k), int'(bf_a_addr), exp_a[k]);
         check_eq($sformatf("bf_b_%0d", k), int'(bf_b_addr), exp_b[k]);
         check_eq($sformatf("bf_tw_%0d", k), int'(bf_tw_idx), exp_tw[k]);
         check_eq($sformatf("bf_stage_%0d", k), int'(bf_stage), exp_stg[k]);
         check_eq($sformatf("bf_in_ready_%0d", k), int'(in_ready), 0);
         tick();
      end

      // Drain: quiet cycles between last issue and first bin
      d = 0;
      while (!out_valid && d < 20) begin
         check_eq($sformatf("drain_bf_valid_%0d", d), int'(bf_valid), 0);
         check_eq($sformatf("drain_busy_%0d", d), int'(busy), 1);
         d++;
         tick();
      end
      check_eq("drain_cycles", d, int'(PIPE_LAT));

      // Unload with a 4-cycle stall on bin 3
      e = 0;
      stall = 0;
      guard = 0;
      while (e < 8 && guard < 40) begin
         check_eq($sformatf("un_valid_%0d", e), int'(out_valid), 1);
         check_eq($sformatf("un_rd_addr_%0d", e), int'(rd_addr), exp_rd[e]);
         check_eq($sformatf("un_last_%0d", e), int'(out_last), (e == 7) ? 1 : 0);
         check_eq($sformatf("un_in_ready_%0d", e), int'(in_ready), 0);
         check_eq($sformatf("un_load_we_%0d", e), int'(load_we), 0);
         check_eq($sformatf("un_frame_done_%0d", e), int'(frame_done), 0);
         if (e == 3 && stall < 4) begin
            out_ready = 1'b0;
            stall++;
         end else begin
            out_ready = 1'b1;
            if (e == 7) in_valid = 1'b0;
            e++;
         end
         guard++;
         tick();
      end
      check_eq("unload_bins", e, 8);
      check_eq("unload_cycles", guard, 12);
      check_eq("done_pulse", int'(frame_done), 1);
      check_eq("done_in_ready", int'(in_ready), 1);
      check_eq("done_out_valid", int'(out_valid), 0);
      check_eq("done_busy", int'(busy), 0);
      out_ready = 1'b0;
      tick();
      check_eq("done_pulse_end", int'(frame_done), 0);
      check_eq("idle_load_we", int'(load_we), 0);

      // Frame 2: reset in COMPUTE at issue 6
      in_valid = 1'b1;
      #1;
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("f2_load_addr_%0d", i), int'(load_addr), exp_load[i]);
         tick();
      end
      for (int k = 0; k < 6; k++) tick();
      check_eq("f2_issue6_a", int'(bf_a_addr), exp_a[6]);
      check_eq("f2_issue6_valid", int'(bf_valid), 1);
      reset = 1'b1;
      #1;
      check_eq("midrst_bf_valid", int'(bf_valid), 0);
      check_eq("midrst_busy", int'(busy), 0);
      check_eq("midrst_in_ready", int'(in_ready), 0);
      check_eq("midrst_load_we", int'(load_we), 0);
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      #1;
      check_eq("post_rst_in_ready", int'(in_ready), 1);
      check_eq("post_rst_load_addr", int'(load_addr), 0);
      check_eq("post_rst_busy", int'(busy), 0);
      check_eq("post_rst_bf_stage", int'(bf_stage), 0);
      in_valid = 1'b1;
      #1;
      tick();
      in_valid = 1'b0;
      #1;
      check_eq("post_rst_load_addr1", int'(load_addr), exp_load[1]);
      check_eq("post_rst_still_load", int'(busy), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/fft_ctrl.md
# fft_ctrl

Sequencer for the in-place radix-2 DIT FFT datapath. It sits between the FIR output stream and the FFT buffer/butterfly unit. It accepts N samples over a valid/ready handshake and generates the buffer write addresses. It then issues the full schedule of butterfly operand addresses and twiddle indices, one butterfly per cycle. After a pipeline drain it streams the N result-bin read addresses out under a valid/ready handshake.

## Interface
Parameters:
- N, 8, FFT points; power of two, 4..1024
- LOG2N, 3, log2(N)
- PIPE_LAT, 2, butterfly datapath write-back latency in cycles, 0..7

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_valid  in  1  FIR sample available
- in_ready  out  1  controller accepts a sample this cycle
- load_we  out  1  write the current sample into the buffer
- load_addr  out  LOG2N  buffer write address
- bf_valid  out  1  butterfly issue strobe
- bf_a_addr  out  LOG2N  upper butterfly operand address
- bf_b_addr  out  LOG2N  lower butterfly operand address (= a + half)
- bf_tw_idx  out  LOG2N-1  twiddle ROM index, 0..N/2-1
- bf_stage  out  LOG2N  current stage number, 0..LOG2N-1
- out_valid  out  1  result bin address valid
- out_ready  in  1  downstream consumes the bin
- rd_addr  out  LOG2N  buffer read address of the current bin
- out_last  out  1  high with out_valid on bin N-1
- frame_done  out  1  one-cycle pulse, final bin handshake
- busy  out  1  high in COMPUTE, DRAIN or UNLOAD

## Operation
- States: LOAD, COMPUTE, DRAIN, UNLOAD. Reset enters LOAD with all counters at 0.
- All outputs are combinational decodes of registered state and counters, except where stated below.
- **LOAD**
  - in_ready = 1 (forced 0 while reset is high).
  - load_we = in_valid & in_ready.
  - load_addr = bitrev(sample_cnt).
  - sample_cnt increments on each accept.
  - The accept at sample_cnt = N-1 moves the FSM to COMPUTE and clears sample_cnt.
- **COMPUTE**
  - bf_valid = 1 on every cycle. Butterfly counter b runs 0..N/2-1 inside stage s = 0..LOG2N-1.
  - half = 1<<s; pos = b & (half-1); grp = b >> s.
  - bf_a_addr = grp·2·half + pos; bf_b_addr = bf_a_addr + half.
  - bf_tw_idx = pos << (LOG2N-1-s); bf_stage = s.
  - After b = N/2-1 of stage LOG2N-1:
    - go to DRAIN when PIPE_LAT > 0;
    - go directly to UNLOAD when PIPE_LAT = 0.
  - The controller cannot stall the schedule; the datapath is required to accept one butterfly per cycle.
- **DRAIN**
  - Counts PIPE_LAT cycles with all strobes low, then moves to UNLOAD.
- **UNLOAD**
  - out_valid = 1; rd_addr = bin_cnt.
  - bin_cnt advances only on out_valid & out_ready; rd_addr is held stable while stalled.
  - out_last = (bin_cnt == N-1).
- **Frame completion**
  - The handshake on bin N-1 registers frame_done = 1 for exactly the next cycle.
  - On that same handshake the FSM returns to LOAD and clears bin_cnt.
- **Backpressure**
  - in_ready = 0 outside LOAD; samples arriving then are not consumed and the FIR must hold them.
- **Reset**
  - Reset asserted in any state immediately returns the FSM to LOAD and zeroes all counters and frame_done.
  - A partial frame is discarded; no strobe may be asserted during reset.
- All counters wrap only through explicit clears; no counter may exceed its range.

## Timing
- Load phase: N handshakes. The minimum is N cycles when in_valid is held high.
- Compute phase: exactly (N/2)·LOG2N cycles; 12 cycles for N=8.
- Drain phase: PIPE_LAT cycles.
- Unload phase: N handshakes; at minimum N cycles.
- Minimum frame period: 2N + (N/2)·LOG2N + PIPE_LAT cycles; 30 for defaults.
- The first bf_valid occurs in the cycle after the Nth load accept.
- out_valid first rises PIPE_LAT cycles after the last bf_valid cycle.
- Reset values: in_ready 0 (1 after release), load_we 0, bf_valid 0, out_valid 0, out_last 0, frame_done 0, busy 0, all address outputs 0.

## Configuration
- Macro: FFT_CTRL_BITREV_EN.
- Defined (default build):
  - load_addr = bitrev(sample_cnt);
  - rd_addr = bin_cnt, so results stream in natural order.
- Undefined:
  - load_addr = sample_cnt;
  - rd_addr = bitrev(bin_cnt), so the reorder is moved to the unload side.
- The butterfly schedule is identical in both builds.

## Test plan
- Reset, then in_valid held high with samples 0..7.
  - Required: load_addr sequence 0,4,2,6,1,5,3,7 (macro defined).
  - Required: in_ready drops on the cycle after the 8th accept.
- Compute schedule, N=8.
  - bf_valid is high for exactly 12 cycles.
  - Issue 0: a=0, b=1, tw=0.
  - Issue 5 (stage 1, b=1): a=1, b=3, tw=2.
  - Issue 11 (stage 2, b=3): a=3, b=7, tw=3.
- Drain/unload timing.
  - out_valid rises exactly 2 cycles after the last bf_valid.
  - rd_addr runs 0..7; out_last is high only at 7.
  - frame_done pulses once and in_ready returns to 1 on the next cycle.
- Backpressure.
  - Toggle out_ready low on bin 3 for 4 cycles.
  - Required: rd_addr is held at 3 and no bin is skipped or repeated.
  - Required: in_ready stays 0 throughout.
- Reset mid-operation.
  - Assert reset in COMPUTE at issue 6.
  - Required: bf_valid immediately 0 and busy 0; after release in_ready = 1 and load_addr = 0.
- Macro undefined build.
  - load_addr is 0..7 in order.
  - Unload rd_addr is 0,4,2,6,1,5,3,7.
